// File: rtl/spi_word_rx.sv
// SPI slave deserializer: oversamples cs/spi_clk/sdi in the clk domain,
// rebuilds MSB-first words and offers them on a valid/ready handshake.
module spi_word_rx #(
  parameter int WORD_BITS   = 10,
  parameter int TIMEOUT_CYC = 4095,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs,
  input  logic                 spi_clk,
  input  logic                 spi_sdi,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int BW = $clog2(WORD_BITS + 2);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] ABORT  = 2'd3;

  logic cs_s1, cs_s2, cs_s3;
  logic ck_s1, ck_s2, ck_s3;
  logic sdi_s1, sdi_s2;

  logic [1:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        tmo;
  logic [WORD_BITS-1:0] shreg;

  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;
  logic good;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_s3  <= 1'b1;
      ck_s1  <= 1'b0;
      ck_s2  <= 1'b0;
      ck_s3  <= 1'b0;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      cs_s1  <= spi_cs;
      cs_s2  <= cs_s1;
      cs_s3  <= cs_s2;
      ck_s1  <= spi_clk;
      ck_s2  <= ck_s1;
      ck_s3  <= ck_s2;
      sdi_s1 <= spi_sdi;
      sdi_s2 <= sdi_s1;
    end
  end

  assign sclk_rise = ck_s2 & ~ck_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign good      = (state == CHECK) &&
                     (bit_cnt == BW'(WORD_BITS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tmo     <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          tmo     <= '0;
          if (cs_fall) state <= ACTIVE;
        end
        ACTIVE: begin
          // cs_rise beats a coincident clock edge
          if (cs_rise) begin
            state <= CHECK;
          end else if (sclk_rise && !cs_s2) begin
            shreg <= {shreg[WORD_BITS-2:0], sdi_s2};
            tmo   <= '0;
            if (bit_cnt != BW'(WORD_BITS + 1))
              bit_cnt <= bit_cnt + 1'b1;
          end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            state <= ABORT;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CHECK: state <= IDLE;
        ABORT: if (cs_s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (state == CHECK && !good)
        frame_err <= 1'b1;
      if (state == ACTIVE && !cs_rise &&
          !(sclk_rise && !cs_s2) &&
          tmo == TW'(TIMEOUT_CYC - 1))
        frame_err <= 1'b1;
      if (good) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: bit-banged SPI master frames,
// hand-computed words, counters and error pulses.
module tb_spi_word_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs;
  logic       spi_clk;
  logic       spi_sdi;
  logic [9:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic [3:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err = 0;
  int n_ovr = 0;

  always #5 clk = ~clk;

  spi_word_rx #(
    .WORD_BITS(10),
    .TIMEOUT_CYC(4095),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_cs(spi_cs),
    .spi_clk(spi_clk),
    .spi_sdi(spi_sdi),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always @(negedge clk) begin
    if (frame_err) n_err++;
    if (overrun) n_ovr++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bits(input logic [15:0] v,
                      input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi = v[i];
      clks(half);
      spi_clk = 1'b1;
      clks(half);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] v,
                       input int n, input int half);
    spi_cs = 1'b0;
    clks(half);
    bits(v, n, half);
    clks(half);
    spi_cs = 1'b1;
    clks(8);
  endtask

  task automatic accept();
    data_ready = 1'b1;
    clks(1);
    data_ready = 1'b0;
  endtask

  int e0, o0, lat;

  initial begin
    reset      = 1'b1;
    spi_cs     = 1'b1;
    spi_clk    = 1'b0;
    spi_sdi    = 1'b0;
    data_ready = 1'b0;
    clks(3);
    reset = 1'b0;
    clks(2);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);

    // 1: slow frame, latency from cs pin
    e0 = n_err;
    spi_cs = 1'b0;
    clks(500);
    bits(16'h00FF, 10, 500);
    clks(500);
    spi_cs = 1'b1;
    lat = 0;
    while (!data_valid && lat < 20) begin
      clks(1);
      lat++;
    end
    check("t1_latency", 32'(lat), 4);
    check("t1_valid", 32'(data_valid), 1);
    check("t1_data", 32'(data_out), 32'h0FF);
    check("t1_cnt", 32'(frame_cnt), 1);
    check("t1_err", 32'(n_err - e0), 0);
    accept();
    check("t1_clear", 32'(data_valid), 0);

    // 2: second frame while first unread
    o0 = n_ovr;
    frame(16'h02A5, 10, 4);
    frame(16'h015A, 10, 4);
    check("t2_data", 32'(data_out), 32'h2A5);
    check("t2_valid", 32'(data_valid), 1);
    check("t2_ovr", 32'(n_ovr - o0), 1);
    check("t2_cnt", 32'(frame_cnt), 3);
    accept();

    // 3: short and long frames
    e0 = n_err;
    frame(16'h01AB, 9, 4);
    frame(16'h0555, 11, 4);
    check("t3_err", 32'(n_err - e0), 2);
    check("t3_valid", 32'(data_valid), 0);
    check("t3_cnt", 32'(frame_cnt), 3);

    // 4: stall past timeout, then recovery
    e0 = n_err;
    spi_cs = 1'b0;
    clks(4);
    bits(16'h0005, 3, 4);
    clks(4200);
    check("t4_err", 32'(n_err - e0), 1);
    spi_cs = 1'b1;
    clks(8);
    check("t4_noval", 32'(data_valid), 0);
    frame(16'h03FF, 10, 4);
    check("t4_valid", 32'(data_valid), 1);
    check("t4_data", 32'(data_out), 32'h3FF);
    check("t4_err1", 32'(n_err - e0), 1);
    accept();

    // 4b: stall just under the timeout is tolerated
    e0 = n_err;
    spi_cs = 1'b0;
    clks(4);
    bits(16'h000E, 5, 4);
    clks(4000);
    bits(16'h0003, 5, 4);
    clks(4);
    spi_cs = 1'b1;
    clks(8);
    check("t4b_err", 32'(n_err - e0), 0);
    check("t4b_data", 32'(data_out), 32'h1C3);
    check("t4b_cnt", 32'(frame_cnt), 5);

    // 5: reset mid-frame with cs held low
    spi_cs = 1'b0;
    clks(4);
    bits(16'h0015, 5, 4);
    reset = 1'b1;
    clks(1);
    reset = 1'b0;
    check("t5_valid", 32'(data_valid), 0);
    check("t5_data", 32'(data_out), 0);
    check("t5_cnt", 32'(frame_cnt), 0);
    e0 = n_err;
    bits(16'h000A, 5, 4);
    clks(4);
    spi_cs = 1'b1;
    clks(8);
    check("t5_err", 32'(n_err - e0), 1);
    check("t5_nov", 32'(data_valid), 0);

    // 6: clock edges with cs high are ignored; counter wrap
    spi_clk = 1'b1;
    clks(4);
    spi_clk = 1'b0;
    clks(4);
    check("t6_idle", 32'(frame_cnt), 0);
    data_ready = 1'b1;
    for (int i = 1; i <= 15; i++)
      frame(16'(i * 7), 10, 3);
    check("t6_cnt15", 32'(frame_cnt), 15);
    check("t6_d15", 32'(data_out), 32'd105);
    frame(16'h0321, 10, 3);
    check("t6_wrap", 32'(frame_cnt), 0);
    check("t6_data", 32'(data_out), 32'h321);
    check("t6_clr", 32'(data_valid), 0);
    data_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
